// File: rtl/bsg_manycore_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bsg_manycore_pkg                                             |
// | Description : Shared manycore types, packet-width helpers and ruche edge   |
// |               polarity helper.                                             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package bsg_manycore_pkg;

   localparam int c_reg_id_width = 5;
   localparam int c_op_width     = 2;
   localparam int c_op_ex_width  = 4;

   typedef enum logic [1:0] {
      e_return_credit   = 2'd0,
      e_return_int_wb   = 2'd1,
      e_return_float_wb = 2'd2,
      e_return_ifetch   = 2'd3
   } bsg_manycore_return_packet_type_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } bsg_ruche_edge_state_e;

   function automatic int bsg_manycore_fwd_packet_width(input int a, input int d, input int x, input int y);
      return a + c_op_width + c_op_ex_width + c_reg_id_width + d + 2*y + 2*x;
   endfunction

   function automatic int bsg_manycore_return_packet_width(input int d, input int x, input int y);
      return 2 + d + c_reg_id_width + y + x;
   endfunction

   // Each channel carries a valid and a ready alongside its packet.
   function automatic int bsg_manycore_ruche_x_link_sif_width(input int a, input int d, input int x, input int y);
      return bsg_manycore_fwd_packet_width(a, d, x, y) + bsg_manycore_return_packet_width(d, x, y) + 4;
   endfunction

   // Returns {invert_input, invert_output} for a ruche edge at the given stage.
   function automatic logic [1:0] bsg_ruche_edge_invert(input int factor, input int stage, input logic west_not_east);
      logic stage_even;
      logic inv_in;
      logic inv_out;
      stage_even = ((stage % 2) == 0);
      if (stage == 0) begin
         inv_in  = 1'b0;
         inv_out = 1'b0;
      end else if ((factor % 2) == 0) begin
         inv_in  = ~stage_even;
         inv_out = ~stage_even;
      end else if (west_not_east) begin
         inv_in  = ~stage_even;
         inv_out = stage_even;
      end else begin
         inv_in  = stage_even;
         inv_out = ~stage_even;
      end
      return {inv_in, inv_out};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_ruche_edge_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bsg_manycore_ruche_edge_sat_counter                          |
// | Description : Saturating up-counter; clear and increment together give 1.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module bsg_manycore_ruche_edge_sat_counter #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               incr_i,
   input  logic               clear_i,
   output logic [width_p-1:0] count_o
);

   localparam logic [width_p-1:0] c_one = {{(width_p-1){1'b0}}, 1'b1};

   logic [width_p-1:0] r_count;
   logic [width_p-1:0] w_count_next;

   always_comb begin
      w_count_next = r_count;
      if (clear_i) begin
         w_count_next = incr_i ? c_one : '0;
      end else if (incr_i && (r_count != '1)) begin
         w_count_next = r_count + c_one;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_ruche_x_edge_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bsg_manycore_ruche_x_edge_sink                               |
// | Description : Active terminator for an unused ruche X edge link: swallows  |
// |               stray packets, credits fwd requests, counts errors.          |
// |               Optional: BSG_MANYCORE_RUCHE_EDGE_CAPTURE_EN (first source   |
// |               capture), BSG_MANYCORE_RUCHE_EDGE_SINK_REPORT (sim messages).|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module bsg_manycore_ruche_x_edge_sink
   import bsg_manycore_pkg::*;
#(
   parameter int addr_width_p     = 10,
   parameter int data_width_p     = 32,
   parameter int x_cord_width_p   = 6,
   parameter int y_cord_width_p   = 5,
   parameter int ruche_factor_X_p = 3,
   parameter int ruche_stage_p    = 1,
   parameter int west_not_east_p  = 0,
   parameter int count_width_p    = 16,
   localparam int link_sif_width_lp =
      bsg_manycore_ruche_x_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic [link_sif_width_lp-1:0] ruche_link_i,
   output logic [link_sif_width_lp-1:0] ruche_link_o,
   input  logic                         clear_i,
   output logic                         err_o,
   output logic [count_width_p-1:0]     fwd_err_count_o,
   output logic [count_width_p-1:0]     rev_err_count_o,
   output logic [x_cord_width_p-1:0]    first_src_x_o,
   output logic [y_cord_width_p-1:0]    first_src_y_o
);

   localparam logic [1:0] c_invert        = bsg_ruche_edge_invert(ruche_factor_X_p, ruche_stage_p, (west_not_east_p != 0));
   localparam logic       invert_input_lp  = c_invert[1];
   localparam logic       invert_output_lp = c_invert[0];

   typedef struct packed {
      logic [addr_width_p-1:0]    addr;
      logic [c_op_width-1:0]      op;
      logic [c_op_ex_width-1:0]   op_ex;
      logic [c_reg_id_width-1:0]  reg_id;
      logic [data_width_p-1:0]    payload;
      logic [y_cord_width_p-1:0]  src_y_cord;
      logic [x_cord_width_p-1:0]  src_x_cord;
      logic [y_cord_width_p-1:0]  y_cord;
      logic [x_cord_width_p-1:0]  x_cord;
   } fwd_pkt_s;

   typedef struct packed {
      bsg_manycore_return_packet_type_e pkt_type;
      logic [data_width_p-1:0]          data;
      logic [c_reg_id_width-1:0]        reg_id;
      logic [y_cord_width_p-1:0]        y_cord;
      logic [x_cord_width_p-1:0]        x_cord;
   } ret_pkt_s;

   typedef struct packed {
      logic     v;
      fwd_pkt_s data;
      logic     ready_and_rev;
   } fwd_chan_s;

   typedef struct packed {
      logic     v;
      ret_pkt_s data;
      logic     ready_and_rev;
   } rev_chan_s;

   typedef struct packed {
      fwd_chan_s fwd;
      rev_chan_s rev;
   } link_sif_s;

   link_sif_s             w_link_in;
   link_sif_s             w_link_out;
   bsg_ruche_edge_state_e r_state;
   bsg_ruche_edge_state_e w_state_next;
   ret_pkt_s              r_ret_pkt;
   ret_pkt_s              w_ret_pkt;
   logic                  w_fwd_ready;
   logic                  w_ret_v;
   logic                  w_fwd_xfer;
   logic                  w_rev_xfer;
   logic                  w_ret_xfer;
   logic                  r_err;
   logic                  w_unused;

   assign w_link_in    = ruche_link_i ^ {link_sif_width_lp{invert_input_lp}};
   assign ruche_link_o = w_link_out   ^ {link_sif_width_lp{invert_output_lp}};

   assign w_fwd_xfer = w_link_in.fwd.v & w_fwd_ready;
   assign w_rev_xfer = w_link_in.rev.v;
   assign w_ret_xfer = w_ret_v & w_link_in.rev.ready_and_rev;

   // State register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_fwd_xfer) w_state_next = RESP;
         RESP:    if (w_ret_xfer) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      w_fwd_ready = 1'b0;
      w_ret_v     = 1'b0;
      case (r_state)
         IDLE:    w_fwd_ready = 1'b1;
         RESP:    w_ret_v     = 1'b1;
         default: w_fwd_ready = 1'b1;
      endcase
   end

   always_comb begin
      w_ret_pkt          = '0;
      w_ret_pkt.pkt_type = e_return_credit;
      w_ret_pkt.reg_id   = w_link_in.fwd.data.reg_id;
      w_ret_pkt.y_cord   = w_link_in.fwd.data.src_y_cord;
      w_ret_pkt.x_cord   = w_link_in.fwd.data.src_x_cord;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_ret_pkt <= '0;
      end else if (w_fwd_xfer) begin
         r_ret_pkt <= w_ret_pkt;
      end
   end

   always_comb begin
      w_link_out                   = '0;
      w_link_out.fwd.ready_and_rev = w_fwd_ready;
      w_link_out.rev.v             = w_ret_v;
      w_link_out.rev.data          = w_ret_v ? r_ret_pkt : '0;
      w_link_out.rev.ready_and_rev = 1'b1;
   end

   // A new errant packet in a clearing cycle leaves the flag set.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_err <= 1'b0;
      end else if (w_fwd_xfer || w_rev_xfer) begin
         r_err <= 1'b1;
      end else if (clear_i) begin
         r_err <= 1'b0;
      end
   end

   assign err_o = r_err;

   bsg_manycore_ruche_edge_sat_counter #(
      .width_p (count_width_p)
   ) u_fwd_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .incr_i   (w_fwd_xfer),
      .clear_i  (clear_i),
      .count_o  (fwd_err_count_o)
   );

   bsg_manycore_ruche_edge_sat_counter #(
      .width_p (count_width_p)
   ) u_rev_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .incr_i   (w_rev_xfer),
      .clear_i  (clear_i),
      .count_o  (rev_err_count_o)
   );

`ifdef BSG_MANYCORE_RUCHE_EDGE_CAPTURE_EN
   logic                      r_captured;
   logic [x_cord_width_p-1:0] r_first_x;
   logic [y_cord_width_p-1:0] r_first_y;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_captured <= 1'b0;
         r_first_x  <= '0;
         r_first_y  <= '0;
      end else if (w_fwd_xfer && (!r_captured || clear_i)) begin
         r_captured <= 1'b1;
         r_first_x  <= w_link_in.fwd.data.src_x_cord;
         r_first_y  <= w_link_in.fwd.data.src_y_cord;
      end else if (clear_i) begin
         r_captured <= 1'b0;
         r_first_x  <= '0;
         r_first_y  <= '0;
      end
   end

   assign first_src_x_o = r_first_x;
   assign first_src_y_o = r_first_y;
`else
   assign first_src_x_o = '0;
   assign first_src_y_o = '0;
`endif

`ifdef BSG_MANYCORE_RUCHE_EDGE_SINK_REPORT
   always @(posedge clk_i) begin
      if (reset_ni && w_fwd_xfer)
         $error("ruche edge sink: errant fwd packet from (x=%0d, y=%0d)",
                w_link_in.fwd.data.src_x_cord, w_link_in.fwd.data.src_y_cord);
      if (reset_ni && w_rev_xfer)
         $error("ruche edge sink: errant rev packet to (x=%0d, y=%0d)",
                w_link_in.rev.data.x_cord, w_link_in.rev.data.y_cord);
   end
`endif

   // Fields an edge sink never needs to look at.
   assign w_unused = ^{w_link_in.fwd.ready_and_rev, w_link_in.fwd.data.addr, w_link_in.fwd.data.op,
                       w_link_in.fwd.data.op_ex, w_link_in.fwd.data.payload, w_link_in.fwd.data.y_cord,
                       w_link_in.fwd.data.x_cord, w_link_in.rev.data};

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_ruche_x_edge_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bsg_manycore_ruche_x_edge_sink                            |
// | Description : Scoreboard bench for the ruche X edge sink (factor 3, stage  |
// |               1, east edge, 4-bit counters).                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_bsg_manycore_ruche_x_edge_sink;

   localparam int c_aw = 10;
   localparam int c_dw = 32;
   localparam int c_xw = 6;
   localparam int c_yw = 5;
   localparam int c_cw = 4;
   localparam int c_lw = 129;
   localparam logic c_inv_in  = 1'b0;
   localparam logic c_inv_out = 1'b1;

   typedef struct packed {
      logic [c_aw-1:0] addr;
      logic [1:0]      op;
      logic [3:0]      op_ex;
      logic [4:0]      reg_id;
      logic [c_dw-1:0] payload;
      logic [c_yw-1:0] src_y_cord;
      logic [c_xw-1:0] src_x_cord;
      logic [c_yw-1:0] y_cord;
      logic [c_xw-1:0] x_cord;
   } fwd_pkt_t;

   typedef struct packed {
      logic [1:0]      pkt_type;
      logic [c_dw-1:0] data;
      logic [4:0]      reg_id;
      logic [c_yw-1:0] y_cord;
      logic [c_xw-1:0] x_cord;
   } ret_pkt_t;

   typedef struct packed {
      logic     v;
      fwd_pkt_t data;
      logic     ready_and_rev;
   } fwd_chan_t;

   typedef struct packed {
      logic     v;
      ret_pkt_t data;
      logic     ready_and_rev;
   } rev_chan_t;

   typedef struct packed {
      fwd_chan_t fwd;
      rev_chan_t rev;
   } link_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clear;
   logic [c_lw-1:0] link_i;
   logic [c_lw-1:0] link_o;
   logic            err;
   logic [c_cw-1:0] fwd_cnt;
   logic [c_cw-1:0] rev_cnt;
   logic [c_xw-1:0] first_x;
   logic [c_yw-1:0] first_y;
   link_t           tb_in;
   link_t           dut_out;
   link_t           raw_out;

   int checks = 0;
   int errors = 0;
   logic [49:0] exp_q[$];
   logic [49:0] exp_first_x;

   assign link_i  = tb_in ^ {c_lw{c_inv_in}};
   assign raw_out = link_o;
   assign dut_out = link_o ^ {c_lw{c_inv_out}};

   always #5 clk = ~clk;

   bsg_manycore_ruche_x_edge_sink #(
      .addr_width_p     (c_aw),
      .data_width_p     (c_dw),
      .x_cord_width_p   (c_xw),
      .y_cord_width_p   (c_yw),
      .ruche_factor_X_p (3),
      .ruche_stage_p    (1),
      .west_not_east_p  (0),
      .count_width_p    (c_cw)
   ) dut (
      .clk_i           (clk),
      .reset_ni        (rst_n),
      .ruche_link_i    (link_i),
      .ruche_link_o    (link_o),
      .clear_i         (clear),
      .err_o           (err),
      .fwd_err_count_o (fwd_cnt),
      .rev_err_count_o (rev_cnt),
      .first_src_x_o   (first_x),
      .first_src_y_o   (first_y)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [49:0] credit(input logic [4:0] reg_id, input logic [c_yw-1:0] y, input logic [c_xw-1:0] x);
      return {2'b00, 32'h0, reg_id, y, x};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fwd(input logic [c_xw-1:0] x, input logic [c_yw-1:0] y, input logic [4:0] reg_id);
      tb_in.fwd.v                    = 1'b1;
      tb_in.fwd.data.addr            = 10'h155;
      tb_in.fwd.data.op              = 2'b01;
      tb_in.fwd.data.op_ex           = 4'hF;
      tb_in.fwd.data.reg_id          = reg_id;
      tb_in.fwd.data.payload         = 32'hDEADBEEF;
      tb_in.fwd.data.src_y_cord      = y;
      tb_in.fwd.data.src_x_cord      = x;
      tb_in.fwd.data.y_cord          = 5'd17;
      tb_in.fwd.data.x_cord          = 6'd40;
   endtask

   // Monitor: a return transfers on the next rising edge when valid and ready are both high here.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && dut_out.rev.v === 1'b1 && tb_in.rev.ready_and_rev === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ret_unexpected actual=%0h required=none", dut_out.rev.data);
         end else begin
            check("ret_pkt", dut_out.rev.data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      tb_in = '0;
      tb_in.rev.ready_and_rev = 1'b1;
      #12;

      // Reset state as seen on the raw, output-inverted link.
      check("rst_raw_fwd_v",     raw_out.fwd.v, 1);
      check("rst_raw_rev_v",     raw_out.rev.v, 1);
      check("rst_raw_fwd_rdy",   raw_out.fwd.ready_and_rev, 0);
      check("rst_raw_rev_rdy",   raw_out.rev.ready_and_rev, 0);
      check("rst_rev_data",      dut_out.rev.data, 0);
      check("rst_err",           err, 0);
      check("rst_fwd_cnt",       fwd_cnt, 0);
      check("rst_rev_cnt",       rev_cnt, 0);
      check("rst_first_x",       first_x, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_fwd_rdy",      dut_out.fwd.ready_and_rev, 1);

      // Single fwd request, return one cycle after accept.
      drive_fwd(6'd5, 5'd2, 5'd7);
      exp_q.push_back(credit(5'd7, 5'd2, 6'd5));
      check("pre_accept_rev_v",  dut_out.rev.v, 0);
      tick();
      tb_in.fwd.v = 1'b0;
      check("resp_rev_v",        dut_out.rev.v, 1);
      check("resp_fwd_rdy",      dut_out.fwd.ready_and_rev, 0);
      check("t1_fwd_cnt",        fwd_cnt, 1);
      check("t1_err",            err, 1);
`ifdef BSG_MANYCORE_RUCHE_EDGE_CAPTURE_EN
      exp_first_x = 50'd5;
`else
      exp_first_x = 50'd0;
`endif
      check("t1_first_x",        first_x, exp_first_x);
      tick();
      check("t1_back_idle_v",    dut_out.rev.v, 0);

      // Back-pressured return with a second request held on the fwd input.
      tb_in.rev.ready_and_rev = 1'b0;
      drive_fwd(6'd9, 5'd3, 5'd12);
      exp_q.push_back(credit(5'd12, 5'd3, 6'd9));
      tick();
      drive_fwd(6'd2, 5'd2, 5'd1);
      for (int i = 0; i < 10; i++) begin
         check("stall_fwd_rdy",  dut_out.fwd.ready_and_rev, 0);
         check("stall_rev_v",    dut_out.rev.v, 1);
         check("stall_ret_data", dut_out.rev.data, credit(5'd12, 5'd3, 6'd9));
         tick();
      end
      tb_in.fwd.v = 1'b0;
      check("stall_fwd_cnt",     fwd_cnt, 2);
      check("stall_first_x",     first_x, exp_first_x);
      tb_in.rev.ready_and_rev = 1'b1;
      tick();
      check("release_rev_v",     dut_out.rev.v, 0);
      check("release_fwd_rdy",   dut_out.fwd.ready_and_rev, 1);

      // Simultaneous fwd and rev with clear: the new packets count.
      drive_fwd(6'd1, 5'd1, 5'd3);
      exp_q.push_back(credit(5'd3, 5'd1, 6'd1));
      tb_in.rev.v = 1'b1;
      tb_in.rev.data = {2'b01, 32'hCAFE0001, 5'd4, 5'd6, 6'd7};
      clear = 1'b1;
      tick();
      tb_in.fwd.v = 1'b0;
      tb_in.rev.v = 1'b0;
      clear = 1'b0;
      check("clr_both_fwd_cnt",  fwd_cnt, 1);
      check("clr_both_rev_cnt",  rev_cnt, 1);
      check("clr_both_err",      err, 1);
`ifdef BSG_MANYCORE_RUCHE_EDGE_CAPTURE_EN
      check("clr_both_first_x",  first_x, 1);
      check("clr_both_first_y",  first_y, 1);
`else
      check("clr_both_first_x",  first_x, 0);
      check("clr_both_first_y",  first_y, 0);
`endif
      tick();

      // Plain clear.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_fwd_cnt",       fwd_cnt, 0);
      check("clr_rev_cnt",       rev_cnt, 0);
      check("clr_err",           err, 0);
      check("clr_first_x",       first_x, 0);

      // Rev counter saturation with 20 back-to-back packets.
      tb_in.rev.v = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tb_in.rev.data.data = 32'(i);
         tick();
         if (i == 13) check("sat_rev_cnt_14", rev_cnt, 14);
      end
      tb_in.rev.v = 1'b0;
      check("sat_rev_cnt",       rev_cnt, 15);
      check("sat_err",           err, 1);
      check("sat_fwd_cnt",       fwd_cnt, 0);

      // Reset while a return is pending.
      tb_in.rev.ready_and_rev = 1'b0;
      drive_fwd(6'd4, 5'd6, 5'd9);
      tick();
      tb_in.fwd.v = 1'b0;
      check("mid_resp_rev_v",    dut_out.rev.v, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_rev_v",   dut_out.rev.v, 0);
      check("async_rst_fwd_cnt", fwd_cnt, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tb_in.rev.ready_and_rev = 1'b1;
      tick();
      check("post_rst_fwd_rdy",  dut_out.fwd.ready_and_rev, 1);
      check("post_rst_rev_v",    dut_out.rev.v, 0);
      check("post_rst_rev_cnt",  rev_cnt, 0);
      check("post_rst_err",      err, 0);

      tick();
      tick();
      check("sb_drained",        exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bsg_manycore_ruche_x_edge_sink.md
Name: bsg_manycore_ruche_x_edge_sink

Overview:
- Active terminator for an unused ruche X link at the array edge (west or east). Drop-in for a passive tie-off.
- Undoes the stage-dependent link inversion, then accepts and discards every stray packet.
- Answers each errant fwd request with a credit return so the sender's credit counter never deadlocks.
- Keeps saturating error counters and a sticky error flag that firmware and DV can read.

Parameters:
- addr_width_p, none (required): manycore packet address width.
- data_width_p, none (required): packet data width.
- x_cord_width_p, none (required): X coordinate width.
- y_cord_width_p, none (required): Y coordinate width.
- ruche_factor_X_p, none (required): ruche factor.
- ruche_stage_p, none (required): ruche stage of this link.
- west_not_east_p, none (required): 1 = west edge, 0 = east edge.
- count_width_p, 16: width of each error counter.
- Localparams invert_input_lp and invert_output_lp:
  - Both are 0 when ruche_stage_p = 0.
  - Factor even: both = ~stage_even.
  - Factor odd, west: output = stage_even, input = ~stage_even.
  - Factor odd, east: output = ~stage_even, input = stage_even.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- ruche_link_i  in  ruche_x_link_sif_width  incoming link, possibly inverted.
- ruche_link_o  out  ruche_x_link_sif_width  outgoing link; inverted by invert_output_lp.
- clear_i  in  1  synchronous clear of the counters and the sticky flag.
- err_o  out  1  sticky: set when any errant packet is seen.
- fwd_err_count_o  out  count_width_p  saturating count of fwd packets.
- rev_err_count_o  out  count_width_p  saturating count of rev packets.
- first_src_x_o  out  x_cord_width_p  src_x of the first errant fwd packet.
- first_src_y_o  out  y_cord_width_p  src_y of the first errant fwd packet.

Behaviour:
- Polarity: internal view = ruche_link_i XOR {invert_input_lp}. ruche_link_o = internal out XOR {invert_output_lp}.
- Reset: while reset_ni = 0 and after release until a packet arrives:
  - internal out: all valids 0, data 0, fwd.ready_and_rev = 1, rev.ready_and_rev = 1;
  - err_o = 0, counters 0, first_* = 0, FSM = IDLE.
- Handshake: ready-and-valid on both channels. A transfer occurs when v and ready are high on the same rising edge.
- rev input: ready is always 1. Each valid transfer:
  - increments rev_err_count_o, saturating at all-ones;
  - sets err_o. No other action.
- FSM, states IDLE and RESP:
  - IDLE: fwd ready = 1. On a fwd transfer: latch the return packet, increment fwd_err_count_o (saturating), set err_o, go to RESP next cycle.
  - Latched return packet: pkt_type = e_return_credit, data = 0, reg_id copied from the request, y_cord = req src_y, x_cord = req src_x.
  - RESP: fwd ready = 0 and rev output v = 1, holding the latched packet stable. On rev output ready = 1, go to IDLE.
  - Throughput: at most one fwd request every 2 cycles. Minimum latency is request accept to return valid = 1 cycle.
- Simultaneous fwd and rev inbound in the same cycle: both are accepted and both counters increment.
- clear_i:
  - clears counters, err_o and first_* that cycle;
  - if a packet transfers in the same cycle, clear wins, then the count is 1 (the new packet counts);
  - does not affect the FSM or a pending return.
- Saturation: counters hold at 2^count_width_p − 1; err_o stays set.
- Reset mid-RESP: the pending return is dropped and the FSM goes to IDLE asynchronously. This loss is accepted because the whole array resets together.
- Simulation only: an $error on every errant packet, with coordinates.

Optional Feature:
- Macro: BSG_MANYCORE_RUCHE_EDGE_CAPTURE_EN.
- Defined: first_src_x_o and first_src_y_o latch from the first fwd transfer after reset or clear_i, then hold.
- Undefined: no capture flops; first_* are tied to 0. Counters and err_o are unaffected.

Decomposition:
- bsg_manycore_pkg gets:
  - typedef bsg_ruche_edge_state_e {IDLE, RESP};
  - a helper function computing invert_input and invert_output from factor, stage and west_not_east, shared with other ruche edge blocks.
- Packet structs come from existing bsg_manycore_defines.svh macros.
- One sub-module, bsg_manycore_ruche_edge_sat_counter:
  - parameter width_p, inputs incr_i and clear_i, saturating, async active-low reset;
  - instantiated twice.

Test Plan:
- Reset, factor 3, stage 1, east (invert_output = 1, invert_input = 0) -> ruche_link_o valids raw = 1, readies raw = 0, i.e. internally idle and ready; err_o = 0.
- One fwd request, src (x 5, y 2), reg_id 7, rev ready held 1 -> rev v goes high 1 cycle after accept with credit return to (5,2) and reg_id 7; fwd_err_count_o = 1; err_o = 1; first_src_x_o = 5 with the macro, 0 without.
- Rev ready held 0 for 10 cycles during RESP -> fwd ready stays 0 and the return packet stays stable; release -> accepted, FSM returns to IDLE.
- fwd and rev valid in the same cycle, with clear_i asserted -> both counters = 1, err_o = 1.
- count_width_p = 4, 20 back-to-back rev packets -> rev_err_count_o saturates at 15.
- Reset_ni asserted while in RESP -> rev v drops immediately; after release, FSM is IDLE and all counters are 0.
